// File: rtl/scrambler_pkg.sv
// Shared constants and LFSR helper for the N-byte scrambler.
// LFSR kept in reflected (right-shift) Galois form so the scramble byte is s[7:0].
package scrambler_pkg;

    localparam int          LFSR_W   = 16;
    localparam logic [15:0] LFSR_TAP = 16'h9C00;
    localparam logic [15:0] SEED_DEF = 16'hFFFF;
    localparam logic [7:0]  COM_DEF  = 8'hBC;
    localparam logic [7:0]  SKIP_DEF = 8'h1C;

    function automatic logic [LFSR_W-1:0] lfsr_adv8(input logic [LFSR_W-1:0] s);
        logic [LFSR_W-1:0] r;
        r = s;
        for (int i = 0; i < 8; i++) begin
            r = (r >> 1) ^ (r[0] ? LFSR_TAP : '0);
        end
        return r;
    endfunction

endpackage

// File: rtl/scrambler_lane.sv
// One byte lane of the scrambler chain: scrambles a byte and
// produces the LFSR state handed to the next lane.
module scrambler_lane
    import scrambler_pkg::*;
#(
    parameter logic [15:0] SEED = SEED_DEF,
    parameter logic [7:0]  COM  = COM_DEF,
    parameter logic [7:0]  SKIP = SKIP_DEF
) (
    input  logic [LFSR_W-1:0] s_i,
    input  logic [7:0]        din_i,
    input  logic              k_i,
    input  logic              dis_i,
    output logic [7:0]        dout_o,
    output logic [LFSR_W-1:0] s_o
);

    logic is_com;
    logic is_skip;

    assign is_com  = k_i && (din_i == COM);
    assign is_skip = k_i && (din_i == SKIP);

    assign dout_o = (k_i || dis_i) ? din_i : (din_i ^ s_i[7:0]);

    always_comb begin
        s_o = lfsr_adv8(s_i);
        unique case (1'b1)
            is_com:  s_o = SEED;
            is_skip: s_o = s_i;
            default: s_o = lfsr_adv8(s_i);
        endcase
    end

endmodule

// File: rtl/scrambler_nbyte.sv
// NB-lane scrambler/descrambler with valid/ready and one output register.
// Define SCRAMBLER_NBYTE_STATS_EN to add saturating COM/SKIP lane counters.
module scrambler_nbyte
    import scrambler_pkg::*;
#(
    parameter int          NB   = 4,
    parameter logic [15:0] SEED = SEED_DEF,
    parameter logic [7:0]  COM  = COM_DEF,
    parameter logic [7:0]  SKIP = SKIP_DEF
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [8*NB-1:0] din,
    input  logic [NB-1:0]   k_in,
    input  logic            dis_scrambler_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [8*NB-1:0] dout,
    output logic [NB-1:0]   k_out,
    output logic            dis_scrambler_out
`ifdef SCRAMBLER_NBYTE_STATS_EN
    ,
    output logic [15:0]     com_cnt,
    output logic [15:0]     skip_cnt
`endif
);

    logic              accept;
    logic              valid_q, valid_d;
    logic [LFSR_W-1:0] lfsr_q;
    logic [8*NB-1:0]   dout_q, dout_d;
    logic [NB-1:0]     kout_q;
    logic              dis_q;
    logic [LFSR_W-1:0] s [NB+1];

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign valid_d  = accept ? 1'b1 : (out_ready ? 1'b0 : valid_q);

    assign s[0] = lfsr_q;

    for (genvar i = 0; i < NB; i++) begin : g_lane
        scrambler_lane #(
            .SEED (SEED),
            .COM  (COM),
            .SKIP (SKIP)
        ) u_lane (
            .s_i    (s[i]),
            .din_i  (din[8*i +: 8]),
            .k_i    (k_in[i]),
            .dis_i  (dis_scrambler_in),
            .dout_o (dout_d[8*i +: 8]),
            .s_o    (s[i+1])
        );
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            lfsr_q  <= SEED;
            valid_q <= 1'b0;
            dout_q  <= '0;
            kout_q  <= '0;
            dis_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (accept) begin
                lfsr_q <= s[NB];
                dout_q <= dout_d;
                kout_q <= k_in;
                dis_q  <= dis_scrambler_in;
            end
        end
    end

    assign out_valid         = valid_q;
    assign dout              = dout_q;
    assign k_out             = kout_q;
    assign dis_scrambler_out = dis_q;

`ifdef SCRAMBLER_NBYTE_STATS_EN
    logic [3:0]  n_com, n_skip;
    logic [15:0] com_q, com_d, skip_q, skip_d;
    logic [16:0] com_sum, skip_sum;

    always_comb begin
        n_com  = '0;
        n_skip = '0;
        for (int i = 0; i < NB; i++) begin
            n_com  = n_com  + 4'(k_in[i] && (din[8*i +: 8] == COM));
            n_skip = n_skip + 4'(k_in[i] && (din[8*i +: 8] == SKIP));
        end
    end

    // Widen by one bit so overflow shows up as the saturation flag.
    assign com_sum  = {1'b0, com_q}  + 17'(n_com);
    assign skip_sum = {1'b0, skip_q} + 17'(n_skip);
    assign com_d    = com_sum[16]  ? 16'hFFFF : com_sum[15:0];
    assign skip_d   = skip_sum[16] ? 16'hFFFF : skip_sum[15:0];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            com_q  <= '0;
            skip_q <= '0;
        end else if (accept) begin
            com_q  <= com_d;
            skip_q <= skip_d;
        end
    end

    assign com_cnt  = com_q;
    assign skip_cnt = skip_q;
`endif

endmodule
